ircam_frame_tx: RTL and testbench

//  Thermal-camera frame transmitter: the sending end of the IRCAM UART link.
//  - Serialises one frame per start pulse as UART 8N1, LSB first, line idles high.
//  - Pixel words come from an upstream valid/ready source.
//  - Used as a sensor emulator for bench and loopback testing of the IRCAM receive path.
//  - Frame bytes, in order: 5A 5A | LEN_L LEN_H | NPIX pixels (lo,hi) | AMB_L AMB_H | CKS_L CKS_H.

---
 rtl/ircam_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_ircam_frame_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ircam_frame_tx.sv
// ircam_frame_tx
//   Sending end of the IRCAM UART link. One start pulse sends one frame as
//   UART 8N1 bytes (LSB first, line idles high):
//     5A 5A | LEN_L LEN_H | NPIX x (pix_lo pix_hi) | AMB_L AMB_H | CKS_L CKS_H
//   LEN = 2*NPIX+2. CKS = 0x5A5A + LEN + all pixels + ambient, mod 2^16.
// Ports
//   clk50M, rst_n        : clock, asynchronous active-low reset
//   start                : one-cycle frame request, ignored while busy
//   ambient[15:0]        : latched when start is accepted
//   pix_data/valid/ready : upstream pixel handshake (ready only in PIX_REQ)
//   uart_tx              : registered serial line
//   busy                 : frame in progress
//   byte_done            : pulse in the last cycle of each byte's final stop bit
//   frame_done           : pulse with the byte_done of the last checksum byte
module ircam_frame_tx #(
    parameter int NPIX      = 768,
    parameter int BAUD_DIV  = 108,
    parameter int STOP_BITS = 1
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ambient,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic        byte_done,
    output logic        frame_done
);

    localparam logic [15:0] LEN      = 16'(2 * NPIX + 2);
    localparam int          CW       = $clog2(NPIX + 1);
    localparam int          BW       = $clog2(BAUD_DIV + 1);
    // bit index 0 = start bit, 1..8 = data, 9.. = stop bits
    localparam logic [3:0]  LAST_BIT = 4'(8 + STOP_BITS);

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, LEN_L, LEN_H, PIX_REQ, PIX_L, PIX_H,
        AMB_L, AMB_H, CKS_L, CKS_H
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic [15:0]     amb_q, amb_d;
    logic [7:0]      pix_hi_q, pix_hi_d;
    logic [15:0]     cks_q, cks_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // serialiser
    logic            act_q, tx_q;
    logic [7:0]      sh_q;
    logic [3:0]      bit_q;
    logic [BW-1:0]   baud_q;
    logic            tick, ser_done;
    logic            load;
    logic [7:0]      load_byte;

    assign tick       = act_q && (baud_q == BW'(BAUD_DIV - 1));
    assign ser_done   = tick && (bit_q == LAST_BIT);
    assign byte_done  = ser_done;
    assign frame_done = ser_done && (state_q == CKS_H);
    assign pix_ready  = (state_q == PIX_REQ) && !act_q;
    assign uart_tx    = tx_q;
    assign busy       = busy_q;

    // Each byte state is the byte currently on the line; the next byte is
    // loaded in the done cycle so consecutive bytes run back to back.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        amb_d     = amb_q;
        pix_hi_d  = pix_hi_q;
        cks_d     = cks_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_byte = 8'h00;
        case (state_q)
            IDLE: if (start) begin
                state_d   = HDR0;
                busy_d    = 1'b1;
                amb_d     = ambient;
                cnt_d     = '0;
                cks_d     = 16'h5A5A + LEN;
                load      = 1'b1;
                load_byte = 8'h5A;
            end
            HDR0:  if (ser_done) begin state_d = HDR1;  load = 1'b1; load_byte = 8'h5A;     end
            HDR1:  if (ser_done) begin state_d = LEN_L; load = 1'b1; load_byte = LEN[7:0];  end
            LEN_L: if (ser_done) begin state_d = LEN_H; load = 1'b1; load_byte = LEN[15:8]; end
            LEN_H: if (ser_done) state_d = PIX_REQ;
            PIX_REQ: if (pix_valid && pix_ready) begin
                state_d   = PIX_L;
                pix_hi_d  = pix_data[15:8];
                cks_d     = cks_q + pix_data;
                cnt_d     = cnt_q + CW'(1);
                load      = 1'b1;
                load_byte = pix_data[7:0];
            end
            PIX_L: if (ser_done) begin state_d = PIX_H; load = 1'b1; load_byte = pix_hi_q; end
            PIX_H: if (ser_done) begin
                if (cnt_q < CW'(NPIX)) begin
                    state_d = PIX_REQ;
                end else begin
                    state_d   = AMB_L;
                    cks_d     = cks_q + amb_q;
                    load      = 1'b1;
                    load_byte = amb_q[7:0];
                end
            end
            AMB_L: if (ser_done) begin state_d = AMB_H; load = 1'b1; load_byte = amb_q[15:8]; end
            AMB_H: if (ser_done) begin state_d = CKS_L; load = 1'b1; load_byte = cks_q[7:0];  end
            CKS_L: if (ser_done) begin state_d = CKS_H; load = 1'b1; load_byte = cks_q[15:8]; end
            CKS_H: if (ser_done) begin state_d = IDLE;  busy_d = 1'b0; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            amb_q    <= '0;
            pix_hi_q <= '0;
            cks_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            amb_q    <= amb_d;
            pix_hi_q <= pix_hi_d;
            cks_q    <= cks_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            tx_q   <= 1'b1;
            sh_q   <= '0;
            bit_q  <= '0;
            baud_q <= '0;
        end else if (load) begin
            // start bit goes out on the very next cycle
            act_q  <= 1'b1;
            tx_q   <= 1'b0;
            sh_q   <= load_byte;
            bit_q  <= '0;
            baud_q <= '0;
        end else if (tick) begin
            baud_q <= '0;
            bit_q  <= bit_q + 4'd1;
            if (bit_q == LAST_BIT) begin
                act_q <= 1'b0;
                tx_q  <= 1'b1;
            end else if (bit_q < 4'd8) begin
                tx_q <= sh_q[0];
                sh_q <= {1'b0, sh_q[7:1]};
            end else begin
                tx_q <= 1'b1;
            end
        end else if (act_q) begin
            baud_q <= baud_q + BW'(1);
        end
    end

endmodule

// File: tb/tb_ircam_frame_tx.sv
module tb_ircam_frame_tx;

    localparam int DIV_A = 8;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n = 1'b0, rst_a = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // functional DUT (NPIX=4, fast baud)
    logic start_a = 0, pv_a = 0;
    logic [15:0] amb_a = 0, pix_a = 0;
    logic pr_a, tx_a, busy_a, bd_a, fd_a;
    // timing DUTs (BAUD_DIV=108, STOP 1 and 2)
    logic start_t = 0, pv_t = 0;
    logic [15:0] amb_t = 16'h1111, pix_t = 16'h2222;
    logic pr_t1, tx_t1, busy_t1, bd_t1, fd_t1;
    logic pr_t2, tx_t2, busy_t2, bd_t2, fd_t2;
    // full-size DUT (NPIX=768)
    logic start_b = 0, pv_b = 0;
    logic [15:0] amb_b = 0, pix_b = 0;
    logic pr_b, tx_b, busy_b, bd_b, fd_b;

    ircam_frame_tx #(.NPIX(4), .BAUD_DIV(DIV_A), .STOP_BITS(1)) u_a (
        .clk50M(clk), .rst_n(rst_a), .start(start_a), .ambient(amb_a), .pix_data(pix_a),
        .pix_valid(pv_a), .pix_ready(pr_a), .uart_tx(tx_a), .busy(busy_a),
        .byte_done(bd_a), .frame_done(fd_a));
    ircam_frame_tx #(.NPIX(4), .BAUD_DIV(108), .STOP_BITS(1)) u_t1 (
        .clk50M(clk), .rst_n(rst_n), .start(start_t), .ambient(amb_t), .pix_data(pix_t),
        .pix_valid(pv_t), .pix_ready(pr_t1), .uart_tx(tx_t1), .busy(busy_t1),
        .byte_done(bd_t1), .frame_done(fd_t1));
    ircam_frame_tx #(.NPIX(4), .BAUD_DIV(108), .STOP_BITS(2)) u_t2 (
        .clk50M(clk), .rst_n(rst_n), .start(start_t), .ambient(amb_t), .pix_data(pix_t),
        .pix_valid(pv_t), .pix_ready(pr_t2), .uart_tx(tx_t2), .busy(busy_t2),
        .byte_done(bd_t2), .frame_done(fd_t2));
    ircam_frame_tx #(.NPIX(768), .BAUD_DIV(DIV_B), .STOP_BITS(1)) u_b (
        .clk50M(clk), .rst_n(rst_n), .start(start_b), .ambient(amb_b), .pix_data(pix_b),
        .pix_valid(pv_b), .pix_ready(pr_b), .uart_tx(tx_b), .busy(busy_b),
        .byte_done(bd_b), .frame_done(fd_b));

    int checks = 0, passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // hand-computed frames
    logic [15:0] pix_set_a [4] = '{16'h0BB8, 16'h0C1C, 16'h0A8C, 16'h0F3C};
    logic [15:0] pix_set_b [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [7:0]  fr_a [16] = '{8'h5A, 8'h5A, 8'h0A, 8'h00, 8'hB8, 8'h0B, 8'h1C, 8'h0C,
                               8'h8C, 8'h0A, 8'h3C, 8'h0F, 8'hF0, 8'h0A, 8'hF0, 8'h96};
    logic [7:0]  fr_b [16] = '{8'h5A, 8'h5A, 8'h0A, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF,
                               8'h00, 8'h80, 8'hFF, 8'h7F, 8'h34, 8'h12, 8'h97, 8'h6C};
    logic [15:0] pset [4];

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    // UART line monitors: decode each byte mid-bit and score it
    int   dact [2] = '{0, 0};
    int   dcnt [2] = '{0, 0};
    logic [7:0] dsh [2];
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic tx, rs;
            int   dv, n;
            logic [7:0] e;
            tx = (k == 0) ? tx_a : tx_b;
            rs = (k == 0) ? rst_a : rst_n;
            dv = (k == 0) ? DIV_A : DIV_B;
            if (!rs) dact[k] = 0;
            else if (dact[k] == 0) begin
                if (!tx) begin dact[k] = 1; dcnt[k] = 0; end
            end else begin
                dcnt[k]++;
                if (dcnt[k] > dv / 2 && (dcnt[k] - dv / 2) % dv == 0) begin
                    n = (dcnt[k] - dv / 2) / dv;
                    if (n <= 8) dsh[k] = {tx, dsh[k][7:1]};
                    else begin
                        dact[k] = 0;
                        if (k == 0 && exp_a.size() == 0) chk("unexpected_byte_a", 1, 0);
                        else if (k == 1 && exp_b.size() == 0) chk("unexpected_byte_b", 1, 0);
                        else begin
                            e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
                            chk((k == 0) ? "byte_a" : "byte_b", {23'd0, tx, dsh[k]}, {23'd0, 1'b1, e});
                        end
                    end
                end
            end
        end
    end

    int bd_cnt_a = 0, fd_cnt_a = 0, bd_cnt_b = 0, fd_cnt_b = 0;
    initial forever begin
        @(negedge clk);
        if (bd_a) bd_cnt_a++;
        if (fd_a) fd_cnt_a++;
        if (bd_b) bd_cnt_b++;
        if (fd_b) fd_cnt_b++;
    end

    task automatic push_a(input bit use_b);
        for (int i = 0; i < 16; i++) exp_a.push_back(use_b ? fr_b[i] : fr_a[i]);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // feeds n pixels from pset; pixel hold_idx is withheld 5000 cycles once the DUT asks
    task automatic feed_a(input int n, input int hold_idx);
        for (int i = 0; i < n; i++) begin
            int w, bad;
            w = 0;
            pix_a = pset[i];
            pv_a  = (i != hold_idx);
            while (!pr_a && w < 20000) begin @(negedge clk); w++; end
            if (w >= 20000) begin chk("pix_ready_timeout", 1, 0); pv_a = 1'b0; return; end
            if (i == hold_idx) begin
                bad = 0;
                repeat (5000) begin @(negedge clk); if (!tx_a) bad++; end
                chk("stall_line_idle", bad, 0);
                pv_a = 1'b1;
            end
            @(negedge clk);
        end
        pv_a = 1'b0;
    endtask

    task automatic wait_fd_a();
        int w;
        w = 0;
        while (!fd_a && w < 20000) begin @(negedge clk); w++; end
        chk("frame_done_seen", int'(w < 20000), 1);
        chk("busy_at_frame_done", busy_a, 1);
        @(negedge clk);
        chk("busy_fall", busy_a, 0);
    endtask

    task automatic run_a();
        int bd0, fd0;
        // 1: basic frame, valid held high
        pset = pix_set_a; amb_a = 16'h0AF0;
        bd0 = bd_cnt_a; fd0 = fd_cnt_a;
        push_a(0); pulse_a();
        chk("first_fall", tx_a, 0);
        feed_a(4, -1); wait_fd_a();
        chk("byte_done_count", bd_cnt_a - bd0, 16);
        chk("frame_done_count", fd_cnt_a - fd0, 1);
        // 2: pixel source stalls before pixel 2
        fd0 = fd_cnt_a;
        push_a(0); pulse_a();
        feed_a(4, 2); wait_fd_a();
        repeat (100) @(negedge clk);
        chk("stall_frame_done_count", fd_cnt_a - fd0, 1);
        // 4: start mid-frame ignored, then start in the cycle busy falls
        push_a(0); pulse_a();
        repeat (200) @(negedge clk);
        chk("busy_mid_frame", busy_a, 1);
        pulse_a();
        feed_a(4, -1); wait_fd_a();
        pset = pix_set_b; amb_a = 16'h1234;
        push_a(1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; amb_a = 16'h0000;  // ambient must already be latched
        chk("restart_fall", tx_a, 0);
        chk("restart_busy", busy_a, 1);
        feed_a(4, -1); wait_fd_a();
        // 5: reset during PIX_H data bits
        pset = pix_set_a; amb_a = 16'h0AF0;
        push_a(0); pulse_a();
        feed_a(1, -1);
        repeat (110) @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rst_uart_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_pix_ready", pr_a, 0);
        exp_a.delete();
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_line", tx_a, 1);
        fd0 = fd_cnt_a;
        push_a(0); pulse_a();
        feed_a(4, -1); wait_fd_a();
        chk("post_rst_frame_done", fd_cnt_a - fd0, 1);
    endtask

    task automatic run_t();
        int t0, r1, r2;
        int b1 [$];
        int b2 [$];
        int f = 0;
        r1 = -1; r2 = -1;
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        t0 = cyc;
        chk("t1_fall", tx_t1, 0);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (bd_t1) b1.push_back(cyc);
            if (bd_t2) b2.push_back(cyc);
            if (fd_t1 || fd_t2) f++;
            if (tx_t1 && r1 < 0) r1 = cyc;
            if (tx_t2 && r2 < 0) r2 = cyc;
        end
        // 0x5A: start bit and d0 are low, so the first rise is two bits in
        chk("t1_first_rise", r1 - t0, 216);
        chk("t2_first_rise", r2 - t0, 216);
        chk("t1_bytes", b1.size(), 4);
        chk("t2_bytes", b2.size(), 4);
        if (b1.size() == 4) begin
            chk("t1_first_done", b1[0] - t0, 1079);
            for (int i = 1; i < 4; i++) chk("t1_byte_period", b1[i] - b1[i-1], 1080);
        end
        if (b2.size() == 4) begin
            chk("t2_first_done", b2[0] - t0, 1187);
            for (int i = 1; i < 4; i++) chk("t2_byte_period", b2[i] - b2[i-1], 1188);
        end
        chk("t_no_frame_done", f, 0);
        chk("t1_waits_pixel", pr_t1, 1);
        chk("t2_waits_pixel", pr_t2, 1);
        chk("t1_busy", busy_t1, 1);
    endtask

    task automatic run_b();
        int w;
        w = 0;
        pix_b = 16'hFFFF; amb_b = 16'hFFFF; pv_b = 1'b1;
        exp_b.push_back(8'h5A); exp_b.push_back(8'h5A);
        exp_b.push_back(8'h02); exp_b.push_back(8'h06);
        for (int i = 0; i < 2 * 768 + 2; i++) exp_b.push_back(8'hFF);
        exp_b.push_back(8'h5B); exp_b.push_back(8'h5D);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (!fd_b && w < 40000) begin @(negedge clk); w++; end
        chk("b_frame_done_seen", int'(w < 40000), 1);
        repeat (4) @(negedge clk);
        chk("b_byte_count", bd_cnt_b, 1544);
        chk("b_busy_end", busy_b, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_a", tx_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ready_a", pr_a, 0);
        chk("rst_pulses_a", {30'd0, bd_a, fd_a}, 0);
        chk("rst_tx_t", {30'd0, tx_t1, tx_t2}, 3);
        chk("rst_ready_b", pr_b, 0);
        rst_n = 1'b1; rst_a = 1'b1;
        repeat (2) @(negedge clk);
        fork
            run_a();
            run_t();
            run_b();
        join
        repeat (50) @(negedge clk);
        chk("exp_a_drained", exp_a.size(), 0);
        chk("exp_b_drained", exp_b.size(), 0);
        chk("b_frame_done_count", fd_cnt_b, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
